uart_tx_param: RTL and testbench

- Parametrised UART serial transmitter; next generation of the board's simple switch-driven transmitter.
- Accepts a parallel word over a valid/ready handshake and serialises it LSB-first as a framed asynchronous bit stream: start, data, optional parity, 1–2 stop bits.
- Bit timing is derived from the system clock by an internal divider, so no external slow clock is needed.
- Sits between a byte source (switch latch, FIFO or CPU register) and the board TX pin.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_tx_param.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_param.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the parametrised UART transmitter:
//               frame state encoding, parity-mode constants, parity function.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Parity selection codes
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Parity of a word of up to 9 bits; callers zero-extend narrower words,
    // which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [8:0] data, input logic [1:0] mode);
        logic result;
        case (mode)
            PAR_EVEN: result = ^data;
            PAR_ODD:  result = ~^data;
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period divider. Emits a one-cycle tick every CLKS_PER_BIT
//               clocks; a synchronous restart zeroes the phase so each frame
//               starts with a full bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int                 c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Count 0..CLKS_PER_BIT-1 and wrap explicitly; restart wins over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign tick = (r_cnt == c_last);

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param
// Description : Parametrised UART transmitter. Accepts a word on a valid/ready
//               handshake and sends start, DATA_BITS data (LSB first),
//               optional parity and STOP_BITS stop bits on tx_out.
//               Optional line-break generation when UART_TX_BREAK_EN is
//               defined (adds the tx_break input).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef UART_TX_BREAK_EN
    input  logic                 tx_break,
`endif
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 parity_bit
);

    localparam int                 c_idx_w     = $clog2(DATA_BITS + 1);
    localparam logic [c_idx_w-1:0] c_last_bit  = c_idx_w'(DATA_BITS - 1);
    localparam logic [c_idx_w-1:0] c_last_stop = c_idx_w'(STOP_BITS - 1);
    localparam logic [1:0]         c_par_mode  = 2'(PARITY_MODE);

    // Reject illegal configurations at elaboration
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_chk_clks_per_bit
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_chk_parity_mode
        $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    tx_state_t              r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [c_idx_w-1:0]     r_bit_idx;
    logic                   r_tx_out;
    logic                   r_tx_ready;
    logic                   r_parity;
    logic                   w_tick;
    logic                   w_accept;
    logic                   w_restart;

    // r_tx_ready is only ever high in IDLE, so this is the accept condition
    assign w_accept = r_tx_ready & tx_valid;

`ifdef UART_TX_BREAK_EN
    logic r_brk_low;    // line held low while break is requested
    logic r_brk_hold;   // one full bit of mark after break release

    // Restart the divider on frame start and on break release
    assign w_restart = w_accept | (r_brk_low & ~tx_break);
    assign busy      = (r_state != IDLE) | r_brk_low | r_brk_hold;
`else
    assign w_restart = w_accept;
    assign busy      = (r_state != IDLE);
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Frame sequencer: handshake, shift register and registered line outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_tx_out   <= 1'b1;
            r_tx_ready <= 1'b0;
            r_parity   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            r_brk_low  <= 1'b0;
            r_brk_hold <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (r_brk_low) begin
                        if (!tx_break) begin
                            r_brk_low  <= 1'b0;
                            r_brk_hold <= 1'b1;
                            r_tx_out   <= 1'b1;
                        end
                    end else if (r_brk_hold) begin
                        if (w_tick) begin
                            r_brk_hold <= 1'b0;
                            r_tx_ready <= 1'b1;
                        end
                    end else
`endif
                    if (w_accept) begin
                        r_shift    <= tx_data;
                        r_parity   <= calc_parity(9'(tx_data), c_par_mode);
                        r_tx_out   <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_bit_idx  <= '0;
                        r_state    <= START;
                    end else begin
`ifdef UART_TX_BREAK_EN
                        if (tx_break) begin
                            r_brk_low  <= 1'b1;
                            r_tx_out   <= 1'b0;
                            r_tx_ready <= 1'b0;
                        end else
`endif
                        r_tx_ready <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx_out  <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == c_last_bit) begin
                            r_bit_idx <= '0;
                            if (c_par_mode == PAR_NONE) begin
                                r_tx_out <= 1'b1;
                                r_state  <= STOP;
                            end else begin
                                r_tx_out <= r_parity;
                                r_state  <= PARITY;
                            end
                        end else begin
                            r_tx_out  <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + c_idx_w'(1);
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_tx_out  <= 1'b1;
                        r_bit_idx <= '0;
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_bit_idx == c_last_stop) begin
                            r_tx_ready <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_idx_w'(1);
                        end
                    end
                end
                default: begin
                    r_tx_out   <= 1'b1;
                    r_tx_ready <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign tx_out     = r_tx_out;
    assign tx_ready   = r_tx_ready;
    assign parity_bit = r_parity;

endmodule : uart_tx_param
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_param
// Description : Self-checking bench for uart_tx_param. Three instances
//               (8E1, 8O2, 7N1, 4 clocks per bit) are driven with directed
//               and random words; the expected line waveform is built from
//               the frame format (start, data LSB first, parity, stops).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

    localparam int CPB = 4;
    localparam int DB [3] = '{8, 8, 7};
    localparam int PM [3] = '{1, 2, 0};
    localparam int SB [3] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] tx_data [3];
    logic [2:0] tx_valid = 3'b000;
    logic [2:0] brk = 3'b000;
    wire  [2:0] tx_ready;
    wire  [2:0] tx_out;
    wire  [2:0] busy;
    wire  [2:0] parity_bit;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [8:0]  word_q [$];
    bit          exp_bits [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_8e1 (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef UART_TX_BREAK_EN
        .tx_break   (brk[0]),
`endif
        .tx_data    (tx_data[0][7:0]),
        .tx_valid   (tx_valid[0]),
        .tx_ready   (tx_ready[0]),
        .tx_out     (tx_out[0]),
        .busy       (busy[0]),
        .parity_bit (parity_bit[0])
    );

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(2)) u_dut_8o2 (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef UART_TX_BREAK_EN
        .tx_break   (brk[1]),
`endif
        .tx_data    (tx_data[1][7:0]),
        .tx_valid   (tx_valid[1]),
        .tx_ready   (tx_ready[1]),
        .tx_out     (tx_out[1]),
        .busy       (busy[1]),
        .parity_bit (parity_bit[1])
    );

    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_7n1 (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef UART_TX_BREAK_EN
        .tx_break   (brk[2]),
`endif
        .tx_data    (tx_data[2][6:0]),
        .tx_valid   (tx_valid[2]),
        .tx_ready   (tx_ready[2]),
        .tx_out     (tx_out[2]),
        .busy       (busy[2]),
        .parity_bit (parity_bit[2])
    );

    // Single comparison point: counts every check, reports mismatches
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference frame: line level per bit period, and the parity of the word
    task automatic build_frame(input int id, input logic [8:0] w, output int n, output bit par);
        int ones;
        n = 0;
        exp_bits[n] = 1'b0;
        n = n + 1;
        for (int i = 0; i < DB[id]; i++) begin
            exp_bits[n] = w[i];
            n = n + 1;
        end
        ones = $countones(w);
        if (PM[id] == 1) par = ((ones % 2) == 1);
        else if (PM[id] == 2) par = ((ones % 2) == 0);
        else par = 1'b0;
        if (PM[id] != 0) begin
            exp_bits[n] = par;
            n = n + 1;
        end
        for (int s = 0; s < SB[id]; s++) begin
            exp_bits[n] = 1'b1;
            n = n + 1;
        end
    endtask

    // Send every word in word_q on instance id; b2b keeps tx_valid high
    // between words, corrupt changes tx_data two cycles after accept.
    task automatic run_frames(input int id, input bit b2b, input bit corrupt);
        int         n, waited, bad, prev_acc, acc;
        logic [8:0] w, m;
        bit         ep;
        prev_acc = -1;
        m = 9'((1 << DB[id]) - 1);
        while (word_q.size() > 0) begin
            w = word_q.pop_front() & m;
            build_frame(id, w, n, ep);
            tx_data[id]  = w;
            tx_valid[id] = 1'b1;
            waited = 0;
            while (!tx_ready[id] && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            if (!tx_ready[id]) begin
                check_eq("accept_timeout", 32'(waited), 32'd0);
                tx_valid[id] = 1'b0;
                word_q.delete();
                return;
            end
            if (b2b && prev_acc >= 0) check_eq("b2b_wait", 32'(waited), 32'd0);
            @(posedge clk);
            #1;
            acc = int'(cyc);
            if (b2b && prev_acc >= 0) check_eq("b2b_period", 32'(acc - prev_acc), 32'(n * CPB + 1));
            bad = 0;
            for (int k = 1; k <= n * CPB; k++) begin
                @(negedge clk);
                if (tx_out[id] !== exp_bits[(k - 1) / CPB]) bad++;
                if (busy[id] !== 1'b1 || tx_ready[id] !== 1'b0) bad++;
                if (k == 1 && (!b2b || word_q.size() == 0)) tx_valid[id] = 1'b0;
                if (k == 2 && corrupt) tx_data[id] = ~w & m;
            end
            check_eq("frame_wave", 32'(bad), 32'd0);
            check_eq("parity_bit", 32'(parity_bit[id]), 32'(ep));
            @(negedge clk);
            check_eq("end_idle", 32'({tx_ready[id], tx_out[id], busy[id]}), 32'b110);
            prev_acc = acc;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lo, hi, first_rdy, idle_bad;
        logic [8:0] w;
        for (int i = 0; i < 3; i++) tx_data[i] = '0;

        // Reset state while rst_n is held low
        repeat (3) @(negedge clk);
        check_eq("reset_state", 32'({tx_ready[0], tx_out[0], busy[0], parity_bit[0]}), 32'b0100);
        rst_n = 1'b1;
        #1;
        check_eq("ready_low_at_release", 32'(tx_ready[0]), 32'd0);
        @(negedge clk);
        check_eq("ready_after_reset", 32'(tx_ready), 32'b111);

        // Directed frames
        word_q = '{9'h0A5};
        run_frames(0, 1'b0, 1'b0);
        word_q = '{9'h001};
        run_frames(1, 1'b0, 1'b0);
        word_q = '{9'h055, 9'h02A};
        run_frames(2, 1'b1, 1'b0);
        word_q = '{9'h000};
        run_frames(0, 1'b0, 1'b1);

        // Random words, spaced and back-to-back, on every configuration
        for (int pass = 0; pass < 2; pass++) begin
            for (int id = 0; id < 3; id++) begin
                repeat (6) word_q.push_back(9'($urandom));
                run_frames(id, pass[0], 1'($urandom_range(0, 1)));
            end
        end

        // Reset during the 4th data bit of an 8E1 frame
        w = 9'h0B6;
        tx_data[0]  = w;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        tx_valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        check_eq("mid_bit3", 32'(tx_out[0]), 32'(w[3]));
        rst_n = 1'b0;
        #1;
        check_eq("mid_reset_state", 32'({tx_ready[0], tx_out[0], busy[0], parity_bit[0]}), 32'b0100);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_mid_reset", 32'(tx_ready[0]), 32'd1);
        idle_bad = 0;
        repeat (3 * 11 * CPB) begin
            @(negedge clk);
            if (tx_out[0] !== 1'b1 || busy[0] !== 1'b0) idle_bad++;
        end
        check_eq("no_resume", 32'(idle_bad), 32'd0);
        word_q = '{9'h0C3};
        run_frames(0, 1'b0, 1'b0);

`ifdef UART_TX_BREAK_EN
        // Break held for 20 cycles in IDLE, then one bit of mark before ready
        brk[0] = 1'b1;
        lo = 0;
        hi = 0;
        first_rdy = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (first_rdy < 0) begin
                if (tx_ready[0]) first_rdy = k;
                else if (tx_out[0] === 1'b0 && busy[0]) lo++;
                else if (tx_out[0] === 1'b1 && busy[0]) hi++;
            end
            if (k == 20) brk[0] = 1'b0;
        end
        check_eq("brk_low_cycles", 32'(lo), 32'd20);
        check_eq("brk_mark_cycles", 32'(hi), 32'd4);
        check_eq("brk_ready_cycle", 32'(first_rdy), 32'd25);
        word_q = '{9'h03C};
        run_frames(0, 1'b0, 1'b0);
`else
        lo = 0;
        hi = 0;
        first_rdy = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_tx_param
`default_nettype wire
